// File: rtl/patgen_dma.sv
// Test-pattern frame writer: emits WIDTH/4*HEIGHT four-word write bursts in raster order.
// Latency: first memreq one cycle after an accepted start; one idle cycle (NEXT) between bursts.
// Backpressure: holds memreq/memaddr until memack and holds memwdata while memready is low.
// Optional feature: define PATGEN_SCROLL_EN for a per-frame horizontal pattern scroll.
module patgen_dma #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720,
    parameter int BASE   = 0,
    parameter int STRIDE = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [23:0] colour,
    output logic        busy,
    output logic        done,
    output logic [22:0] memaddr,
    output logic [1:0]  memlen,
    output logic [31:0] memwdata,
    output logic        memreq,
    output logic        memwr,
    input  logic        memack,
    input  logic        memready
);

    typedef enum logic [1:0] {IDLE, REQ, DATA, NEXT} state_t;

    state_t      state, state_nxt;
    logic [15:0] x, y;
    logic [1:0]  w;
    logic [1:0]  mode_q;
    logic [23:0] colour_q;
    logic [7:0]  offset;
    logic        line_end, last_burst;
    logic [15:0] p;
    logic [2:0]  bar;
    logic [23:0] rgb;
    logic [22:0] addr;

    assign line_end   = (x + 16'd4) == 16'(WIDTH);
    assign last_burst = line_end && (y == 16'(HEIGHT - 1));

`ifdef PATGEN_SCROLL_EN
    // Scroll offset advances by one pixel after every completed frame.
    always_ff @(posedge clk) begin
        if (rst)
            offset <= 8'd0;
        else if (done)
            offset <= offset + 8'd1;
    end
`else
    assign offset = 8'd0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode; done is the single NEXT cycle that closes the frame.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ:  if (memack) state_nxt = DATA;
            DATA: if (memready && (w == 2'd3)) state_nxt = NEXT;
            NEXT: begin
                if (last_burst) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster position, word counter and per-frame pattern settings.
    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= 16'd0;
            y        <= 16'd0;
            w        <= 2'd0;
            mode_q   <= 2'd0;
            colour_q <= 24'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_q   <= mode;
                    colour_q <= colour;
                    x        <= 16'd0;
                    y        <= 16'd0;
                    w        <= 2'd0;
                end
                // A memready arriving with memack already consumes word 0.
                REQ:  if (memack) w <= memready ? 2'd1 : 2'd0;
                // Counter wraps back to 0 after the fourth word.
                DATA: if (memready) w <= w + 2'd1;
                NEXT: begin
                    if (line_end) begin
                        x <= 16'd0;
                        y <= y + 16'd1;
                    end else begin
                        x <= x + 16'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign p    = x + {14'd0, w} + {8'd0, offset};
    assign bar  = 3'(({p, 3'b000}) / 19'(WIDTH));
    assign addr = 23'(BASE) + 23'(y) * 23'(STRIDE) + 23'(x);

    // Pattern generator for the pixel currently offered on memwdata.
    always_comb begin
        rgb = colour_q;
        case (mode_q)
            2'd0:    rgb = colour_q;
            2'd1:    rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            2'd2:    rgb = {3{p[7:0]}};
            default: rgb = (p[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
        endcase
    end

    // Word 0 is already presented in REQ so a memready coincident with memack has valid data.
    assign memwdata = ((state == REQ) || (state == DATA)) ? {8'h00, rgb} : 32'd0;
    assign memreq   = (state == REQ);
    assign memwr    = memreq;
    assign memlen   = 2'd3;
    assign memaddr  = memreq ? addr : 23'd0;
    assign busy     = (state != IDLE) && !done;

endmodule

// File: tb/tb_patgen_dma.sv
// Directed bench for patgen_dma with an 8x2 frame at BASE 16, STRIDE 32.
// Memory model acks one cycle after memreq and streams memready, with optional stalls.
// Expected addresses and pixels come from the frame geometry and pattern rules.
module tb_patgen_dma;

    localparam int TW = 8;
    localparam int TH = 2;
`ifdef PATGEN_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [23:0] colour;
    logic        busy, done;
    logic [22:0] memaddr;
    logic [1:0]  memlen;
    logic [31:0] memwdata;
    logic        memreq, memwr;
    logic        memack, memready;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int burst_cnt = 0;
    int tb_off = 0;
    logic [22:0] addr_q[$];
    logic [31:0] word_q[$];

    patgen_dma #(.WIDTH(TW), .HEIGHT(TH), .BASE(16), .STRIDE(32)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .colour(colour),
        .busy(busy), .done(done), .memaddr(memaddr), .memlen(memlen),
        .memwdata(memwdata), .memreq(memreq), .memwr(memwr),
        .memack(memack), .memready(memready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled on the active edge.
    always @(posedge clk) begin
        if (done) done_cnt++;
        if (memreq && memack) burst_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_word(input logic [1:0] m, input logic [23:0] c,
                                             input int x, input int y, input int off);
        int pi;
        logic [2:0] bar;
        logic [7:0] g;
        pi  = (x + off) % 65536;
        bar = 3'((pi * 8 / TW) % 8);
        g   = 8'(pi);
        case (m)
            2'd0:    return {8'h00, c};
            2'd1:    return {8'h00, {8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            2'd2:    return {8'h00, g, g, g};
            default: return ((((pi >> 5) ^ (y >> 5)) & 1) != 0) ? 32'h00FFFFFF : 32'h0;
        endcase
    endfunction

    // Starts at a negedge, ends at the following negedge.
    task automatic do_start(input logic [1:0] m, input logic [23:0] c);
        start = 1'b1; mode = m; colour = c;
        @(negedge clk);
        start = 1'b0; mode = 2'd0; colour = 24'd0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL start_busy busy=%b required=1", busy);
        end
    endtask

    // One burst from the memory side; returns at the negedge after the last word is consumed.
    task automatic run_burst(input int stall_at, input int stall_len, input bit coincide, input bit poke);
        int n = 0;
        int k = 0;
        while (memreq !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (memreq !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout memreq=%b required=1", memreq);
            return;
        end
        addr_q.push_back(memaddr);
        checks++;
        if (memlen !== 2'd3 || memwr !== 1'b1) begin
            failures++;
            $display("FAIL req_cmd memlen=%0d memwr=%b required 3 and 1", memlen, memwr);
        end
        memack = 1'b1;
        memready = coincide;
        start = poke;
        if (coincide) begin
            word_q.push_back(memwdata);
            k = 1;
        end
        @(negedge clk);
        memack = 1'b0;
        start = 1'b0;
        checks++;
        if (memreq !== 1'b0) begin
            failures++;
            $display("FAIL ack_drop memreq=%b required=0", memreq);
        end
        while (k < 4) begin
            if (k == stall_at) begin
                memready = 1'b0;
                repeat (stall_len) @(negedge clk);
            end
            memready = 1'b1;
            word_q.push_back(memwdata);
            k++;
            @(negedge clk);
        end
        memready = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] m, input logic [23:0] c, input int stall_burst,
                             input int stall_at, input int stall_len, input int coincide_burst,
                             input bit poke);
        int a0 = addr_q.size();
        int w0 = word_q.size();
        int d0 = done_cnt;
        int b0 = burst_cnt;
        do_start(m, c);
        for (int b = 0; b < 4; b++)
            run_burst((b == stall_burst) ? stall_at : -1, stall_len, b == coincide_burst, poke && b == 1);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_cycle done=%b busy=%b required 1 and 0", done, busy);
        end
        start = poke;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL after_done done=%b busy=%b required 0 and 0", done, busy);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (memreq !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_quiet memreq=%b busy=%b required 0 and 0", memreq, busy);
        end
        checks++;
        if (burst_cnt - b0 != 4 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL frame_counts bursts=%0d dones=%0d required 4 and 1", burst_cnt - b0, done_cnt - d0);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (addr_q[a0 + b] !== 23'(16 + (b / 2) * 32 + (b % 2) * 4)) begin
                failures++;
                $display("FAIL addr[%0d] got=%0d required=%0d", b, addr_q[a0 + b], 16 + (b / 2) * 32 + (b % 2) * 4);
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (word_q[w0 + i] !== exp_word(m, c, ((i / 4) % 2) * 4 + i % 4, i / 8, tb_off)) begin
                failures++;
                $display("FAIL word[%0d] mode=%0d got=%h required=%h", i, m, word_q[w0 + i],
                         exp_word(m, c, ((i / 4) % 2) * 4 + i % 4, i / 8, tb_off));
            end
        end
        if (SCROLL) tb_off = (tb_off + 1) % 256;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; mode = 2'd0; colour = 24'd0; memack = 1'b1; memready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || memreq !== 1'b0 || memwr !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%b done=%b memreq=%b memwr=%b required all 0", busy, done, memreq, memwr);
        end
        checks++;
        if (memlen !== 2'd3 || memaddr !== 23'd0 || memwdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_bus memlen=%0d memaddr=%0d memwdata=%h required 3 0 0", memlen, memaddr, memwdata);
        end
        rst = 1'b0; memack = 1'b0; memready = 1'b0;
        tb_off = 0;
        @(negedge clk);
    endtask

    task automatic test_solid;
        int w0 = word_q.size();
        run_frame(2'd0, 24'h123456, -1, -1, 0, -1, 1'b0);
        for (int i = 0; i < 16; i += 5) begin
            checks++;
            if (word_q[w0 + i] !== 32'h00123456) begin
                failures++;
                $display("FAIL solid_word[%0d] got=%h required=00123456", i, word_q[w0 + i]);
            end
        end
    endtask

    task automatic test_gradient;
        run_frame(2'd2, 24'h0, -1, -1, 0, -1, 1'b0);
    endtask

    task automatic test_stall;
        run_frame(2'd2, 24'h0, 1, 2, 5, -1, 1'b0);
    endtask

    task automatic test_bars_coincide;
        run_frame(2'd1, 24'hFFFFFF, -1, -1, 0, 0, 1'b0);
    endtask

    task automatic test_checker;
        run_frame(2'd3, 24'h0, 2, 0, 3, 3, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_frame(2'd0, 24'hA5C3E1, -1, -1, 0, -1, 1'b1);
        run_frame(2'd0, 24'h0F0F0F, -1, -1, 0, -1, 1'b0);
    endtask

    task automatic test_reset_mid;
        int n = 0;
        do_start(2'd0, 24'hABCDEF);
        run_burst(-1, 0, 1'b0, 1'b0);
        while (memreq !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (memreq !== 1'b1) begin
            failures++;
            $display("FAIL mid_req memreq=%b required=1", memreq);
        end
        memack = 1'b1;
        @(negedge clk);
        memack = 1'b0; memready = 1'b1;
        @(negedge clk);
        rst = 1'b1; memack = 1'b1; memready = 1'b1;
        @(negedge clk);
        checks++;
        if (memreq !== 1'b0 || busy !== 1'b0 || memwdata !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset memreq=%b busy=%b memwdata=%h required 0 0 0", memreq, busy, memwdata);
        end
        rst = 1'b0; memack = 1'b0; memready = 1'b0;
        tb_off = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (memreq !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle memreq=%b busy=%b required 0 0", memreq, busy);
        end
        run_frame(2'd0, 24'h654321, -1, -1, 0, -1, 1'b0);
    endtask

    task automatic test_scroll;
        int w0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tb_off = 0;
        @(negedge clk);
        run_frame(2'd2, 24'h0, -1, -1, 0, -1, 1'b0);
        w0 = word_q.size();
        run_frame(2'd2, 24'h0, -1, -1, 0, -1, 1'b0);
        checks++;
        if (word_q[w0] !== (SCROLL ? 32'h00010101 : 32'h00000000)) begin
            failures++;
            $display("FAIL scroll_first got=%h required=%h", word_q[w0], SCROLL ? 32'h00010101 : 32'h0);
        end
        checks++;
        if (word_q[w0 + 7] !== (SCROLL ? 32'h00080808 : 32'h00070707)) begin
            failures++;
            $display("FAIL scroll_last got=%h required=%h", word_q[w0 + 7], SCROLL ? 32'h00080808 : 32'h00070707);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; colour = 24'd0; memack = 1'b0; memready = 1'b0;
        @(negedge clk);
        test_reset;
        test_solid;
        test_gradient;
        test_stall;
        test_bars_coincide;
        test_checker;
        test_back_to_back;
        test_reset_mid;
        test_scroll;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/patgen_dma.md
PATGEN_DMA -- requirements
Module: patgen_dma

Interface
REQ-001 Parameter WIDTH, default 1280: active pixels per line; SHALL be a multiple of 4.
REQ-002 Parameter HEIGHT, default 720: lines per frame.
REQ-003 Parameter BASE, default 0: 23-bit word address of pixel (0,0).
REQ-004 Parameter STRIDE, default 2048: words between line starts.
REQ-005 Ports SHALL be, clock and reset first:
 clk  in  1  single clock; all logic on its rising edge.
 rst  in  1  synchronous, active-high reset.
 start  in  1  one-cycle pulse; begin writing one frame.
 mode  in  2  pattern select, sampled on accepted start.
 colour  in  24  solid colour {R,G,B}, sampled on accepted start.
 busy  out  1  frame write in progress.
 done  out  1  one-cycle pulse at frame completion.
 memaddr  out  23  burst word address.
 memlen  out  2  burst length minus one; always 3.
 memwdata  out  32  write word {8'h00, R, G, B}.
 memreq  out  1  burst request.
 memwr  out  1  write flag; always 1 while memreq is high.
 memack  in  1  one-cycle pulse; command accepted.
 memready  in  1  high = current memwdata word consumed; may be high on consecutive cycles.

Function
REQ-006 States SHALL be IDLE, REQ, DATA, NEXT.
REQ-007 IDLE: start=1 -> latch mode and colour, x=0, y=0, go to REQ; busy=1 from the next cycle.
REQ-008 REQ: memreq=1, memaddr=BASE+y*STRIDE+x truncated to 23 bits; memaddr, memlen and memwr SHALL be stable until memack.
REQ-009 memack in REQ -> DATA with word counter w=0; memreq SHALL be 0 from the cycle after memack.
REQ-010 DATA: memwdata is a combinational function of (x+w, y, latched mode/colour, offset); each memready cycle increments w; memready with w=3 -> NEXT.
REQ-011 memready coincident with memack SHALL be counted as word 0.
REQ-012 memready in IDLE, REQ or NEXT SHALL be ignored.
REQ-013 NEXT, one cycle: x+=4; if x reaches WIDTH then x=0, y+=1; if the last burst of line HEIGHT-1 is done -> IDLE with done=1 and busy=0 in that cycle; otherwise -> REQ.
REQ-014 Pixel p=(x+w+offset) mod 2^16:
 mode 0: colour.
 mode 1: 8 bars, bar = (p*8/WIDTH) mod 8, colour = {R=bar[2], G=bar[1], B=bar[0]}, each bit expanded to 8'hFF or 8'h00.
 mode 2: gradient R=G=B=p[7:0].
 mode 3: checker, 32-pixel squares, white when p[5]^y[5] else black.
REQ-015 start while busy SHALL be ignored; a start in the done cycle SHALL also be ignored.
REQ-016 Bursts SHALL be issued in raster order; exactly WIDTH/4*HEIGHT bursts per frame.

Reset
REQ-017 rst SHALL force IDLE, x=y=w=0 and offset=0 at the next edge, including mid-burst; pending memack/memready are then ignored.
REQ-018 Output values during and after reset SHALL be busy=0, done=0, memreq=0, memwr=0, memlen=3, memaddr=0, memwdata=0.

Configuration
REQ-019 Macro PATGEN_SCROLL_EN:
 - Defined: 8-bit offset register, incremented (mod 256) on each done pulse, enters REQ-014.
 - Undefined: offset is constant 0 and no register is generated.
 - The port list SHALL be identical in both cases.

Verification
REQ-020 Bench SHALL use WIDTH=8, HEIGHT=2, BASE=16, STRIDE=32, with the memory model acking 1 cycle after memreq and memready on 4 consecutive cycles. Directed scenarios:
 - mode0, colour=24'h123456, one start -> 4 bursts at addresses 16,20,48,52; all 16 words 32'h00123456; one done pulse; busy low afterwards.
 - mode2 -> word values 0..7 on each line.
 - memready held low for 5 cycles mid-burst -> memwdata holds its value; no word skipped or duplicated.
 - start pulsed during busy and in the done cycle -> ignored; exactly 4 bursts per accepted start.
 - rst asserted during DATA of burst 2 -> memreq=0, busy=0 next cycle; a following start restarts at address 16.
 - PATGEN_SCROLL_EN defined, mode2, two frames -> second frame line 0 words 1..8; without the macro -> 0..7 in both frames.
